branch_update_queue: RTL and testbench
======================================

Name: branch_update_queue

Overview:
- Sits between the fetch-side lookup path and the predictor's update port; it is the update-side counterpart of the predictor.
- Captures each looked-up branch index together with the prediction returned for it, and holds these in an in-order FIFO until the branch resolves.
- On resolution it pops the oldest entry and drives a registered one-cycle update (update_en/br_result/correct/idx) back into the predictor.

Parameters:
DEPTH, 8, number of in-flight branches; power of two, minimum 2
IDX_W, 32, width of branch index / PC field

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous reset, active-high
lookup_valid_i  input  1  a branch lookup is issued this cycle
lookup_idx_i  input  IDX_W  index presented to the predictor this cycle
pred_i  input  1  predictor's prediction for lookup_idx_i, same cycle (1 = taken)
lookup_ready_o  output  1  queue can accept a lookup this cycle
resolve_valid_i  input  1  oldest in-flight branch resolves this cycle
resolve_taken_i  input  1  actual outcome of the resolving branch
flush_i  input  1  discard all in-flight entries
update_en_o  output  1  one-cycle update strobe to predictor
br_result_o  output  1  actual outcome for the update
correct_o  output  1  stored prediction equalled actual outcome
idx_o  output  IDX_W  index of the branch being updated
occupancy_o  output  $clog2(DEPTH)+1  entries currently held
resolve_err_o  output  1  sticky: resolve arrived while empty

Behaviour:
- Reset (rst_i=1 at edge): read and write pointers and count = 0; update_en_o, br_result_o, correct_o, idx_o, resolve_err_o all 0; lookup_ready_o = 1 the cycle after reset.
- Storage: DEPTH entries of {idx, pred}. Pointers are log2(DEPTH) bits and wrap naturally at DEPTH.
- lookup_ready_o = (count != DEPTH). It is combinational from the registered count and does not depend on the same-cycle resolve.
- Push: lookup_valid_i && lookup_ready_o writes {lookup_idx_i, pred_i} at the write pointer, then increments it. lookup_valid_i while full is dropped, with no state change.
- Pop: resolve_valid_i && count != 0 reads the head entry and increments the read pointer.
  - On the next cycle: update_en_o = 1, idx_o = head idx, br_result_o = resolve_taken_i (registered), correct_o = (head pred == resolve_taken_i).
  - Latency is exactly 1 cycle from resolve to update.
- update_en_o is 0 in every cycle not following a pop. idx_o, br_result_o and correct_o hold their last values when update_en_o = 0.
- Resolve while count == 0:
  - No pop and no update.
  - resolve_err_o is set to 1 and held until reset.
  - This holds even when a push happens in the same cycle: a same-cycle push is not visible to a resolve.
- Simultaneous push and pop with 0 < count < DEPTH: both occur and count is unchanged.
- Simultaneous push and pop with count == DEPTH: push is refused, pop occurs, and count becomes DEPTH-1.
- Flush:
  - flush_i = 1 clears the pointers and count at the edge.
  - Flush has priority over a same-cycle push and pop: neither takes effect and no update is generated.
  - resolve_err_o is unaffected.
- Reset asserted mid-operation discards all entries. An update that would have appeared in the following cycle is suppressed (update_en_o = 0).
- occupancy_o = registered count, range 0..DEPTH.

Optional Feature:
- Macro: BUQ_STATS_EN.
- When defined, adds two outputs:
  - upd_count_o [31:0]: number of update_en_o pulses issued.
  - mispred_count_o [31:0]: number of those pulses with correct_o = 0.
- Both counters clear on reset, increment in the same cycle update_en_o is high, and wrap from 0xFFFFFFFF to 0. Flush does not clear them.
- When not defined, these ports and their registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then push idx 0x100 with pred 1, then resolve taken = 0 one cycle later -> next cycle update_en_o = 1, idx_o = 0x100, br_result_o = 0, correct_o = 0; occupancy_o returns to 0.
- Push DEPTH = 8 entries (idx 0..7) -> lookup_ready_o = 0 and occupancy_o = 8. A 9th lookup (idx 8) is dropped. Eight resolves then produce updates with idx_o 0..7 in order.
- At full, push and resolve in the same cycle -> occupancy_o = 7, the push is not stored, and exactly one update is issued.
- Resolve with an empty queue, with a push in the same cycle -> no update, resolve_err_o = 1 and held; occupancy_o = 1.
- Hold 3 entries, then assert flush_i together with a resolve -> no update next cycle and occupancy_o = 0. A subsequent push/resolve of idx 0x40 updates with idx_o = 0x40.
- With BUQ_STATS_EN defined, 5 resolves of which 2 are mispredicted -> upd_count_o = 5, mispred_count_o = 2. Reset then clears both to 0.

Source files
------------

// File: rtl/branch_update_queue.sv
// branch_update_queue
//   In-order FIFO of {branch index, prediction} captured at lookup time.
//   Each resolve pops the oldest entry and drives a registered one-cycle
//   update (update_en_o/br_result_o/correct_o/idx_o) back to the predictor.
//   Optional statistics counters are compiled in with `define BUQ_STATS_EN.
module branch_update_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       lookup_valid_i,
  input  logic [IDX_W-1:0]           lookup_idx_i,
  input  logic                       pred_i,
  output logic                       lookup_ready_o,
  input  logic                       resolve_valid_i,
  input  logic                       resolve_taken_i,
  input  logic                       flush_i,
  output logic                       update_en_o,
  output logic                       br_result_o,
  output logic                       correct_o,
  output logic [IDX_W-1:0]           idx_o,
  output logic [$clog2(DEPTH):0]     occupancy_o,
`ifdef BUQ_STATS_EN
  output logic [31:0]                upd_count_o,
  output logic [31:0]                mispred_count_o,
`endif
  output logic                       resolve_err_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Each entry holds {idx, pred}; pred in bit 0.
  logic [IDX_W:0]  mem_q [DEPTH];
  logic [IDX_W:0]  mem_d [DEPTH];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  logic            update_en_q, update_en_d;
  logic            br_result_q, br_result_d;
  logic            correct_q,   correct_d;
  logic [IDX_W-1:0] idx_q,      idx_d;
  logic            resolve_err_q, resolve_err_d;

`ifdef BUQ_STATS_EN
  logic [31:0]     upd_count_q,     upd_count_d;
  logic [31:0]     mispred_count_q, mispred_count_d;
`endif

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [IDX_W:0]  head;
  logic            head_correct;

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  // Flush wins over both push and pop; a same-cycle push never feeds a pop.
  assign push         = lookup_valid_i && !full && !flush_i;
  assign pop          = resolve_valid_i && !empty && !flush_i;
  assign head         = mem_q[rd_ptr_q];
  assign head_correct = (head[0] == resolve_taken_i);

  // Storage write: only the slot at the write pointer changes on a push.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q] = {lookup_idx_i, pred_i};
    end
  end

  // Pointer, count and error-flag next state.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    resolve_err_d = resolve_err_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
    if (resolve_valid_i && empty) begin
      resolve_err_d = 1'b1;
    end
  end

  // Update port next state: strobe follows a pop, data holds otherwise.
  always_comb begin
    update_en_d = pop;
    br_result_d = br_result_q;
    correct_d   = correct_q;
    idx_d       = idx_q;
    if (pop) begin
      br_result_d = resolve_taken_i;
      correct_d   = head_correct;
      idx_d       = head[IDX_W:1];
    end
  end

`ifdef BUQ_STATS_EN
  // Counters advance at the same edge that raises update_en_o.
  always_comb begin
    upd_count_d     = upd_count_q;
    mispred_count_d = mispred_count_q;
    if (pop) begin
      upd_count_d = upd_count_q + 32'd1;
      if (!head_correct) begin
        mispred_count_d = mispred_count_q + 32'd1;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      upd_count_q     <= '0;
      mispred_count_q <= '0;
    end else begin
      upd_count_q     <= upd_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign upd_count_o     = upd_count_q;
  assign mispred_count_o = mispred_count_q;
`endif

  // Entry storage; contents are only meaningful below the count.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // Control and update registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      update_en_q   <= 1'b0;
      br_result_q   <= 1'b0;
      correct_q     <= 1'b0;
      idx_q         <= '0;
      resolve_err_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      update_en_q   <= update_en_d;
      br_result_q   <= br_result_d;
      correct_q     <= correct_d;
      idx_q         <= idx_d;
      resolve_err_q <= resolve_err_d;
    end
  end

  assign lookup_ready_o = !full;
  assign update_en_o    = update_en_q;
  assign br_result_o    = br_result_q;
  assign correct_o      = correct_q;
  assign idx_o          = idx_q;
  assign occupancy_o    = count_q;
  assign resolve_err_o  = resolve_err_q;

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed testbench for branch_update_queue (DEPTH=8, IDX_W=32).
module tb_branch_update_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] lookup_idx;
  logic        pred;
  logic        lookup_ready;
  logic        resolve_valid;
  logic        resolve_taken;
  logic        flush;
  logic        update_en;
  logic        br_result;
  logic        correct;
  logic [31:0] idx;
  logic [3:0]  occupancy;
  logic        resolve_err;
`ifdef BUQ_STATS_EN
  logic [31:0] upd_count;
  logic [31:0] mispred_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_update_queue #(.DEPTH(8), .IDX_W(32)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .lookup_valid_i  (lookup_valid),
    .lookup_idx_i    (lookup_idx),
    .pred_i          (pred),
    .lookup_ready_o  (lookup_ready),
    .resolve_valid_i (resolve_valid),
    .resolve_taken_i (resolve_taken),
    .flush_i         (flush),
    .update_en_o     (update_en),
    .br_result_o     (br_result),
    .correct_o       (correct),
    .idx_o           (idx),
    .occupancy_o     (occupancy),
`ifdef BUQ_STATS_EN
    .upd_count_o     (upd_count),
    .mispred_count_o (mispred_count),
`endif
    .resolve_err_o   (resolve_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    lookup_valid  = 1'b0;
    lookup_idx    = '0;
    pred          = 1'b0;
    resolve_valid = 1'b0;
    resolve_taken = 1'b0;
    flush         = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_occ",   32'(occupancy),   32'd0);
    chk("rst_upd",   32'(update_en),   32'd0);
    chk("rst_idx",   idx,              32'd0);
    chk("rst_br",    32'(br_result),   32'd0);
    chk("rst_corr",  32'(correct),     32'd0);
    chk("rst_err",   32'(resolve_err), 32'd0);
    chk("rst_ready", 32'(lookup_ready), 32'd1);

    // Single push then mispredicted resolve
    lookup_valid = 1'b1; lookup_idx = 32'h100; pred = 1'b1;
    step();
    chk("p1_occ", 32'(occupancy), 32'd1);
    chk("p1_upd_none", 32'(update_en), 32'd0);
    idle_inputs();
    resolve_valid = 1'b1; resolve_taken = 1'b0;
    step();
    chk("p1_upd",  32'(update_en), 32'd1);
    chk("p1_idx",  idx,            32'h100);
    chk("p1_br",   32'(br_result), 32'd0);
    chk("p1_corr", 32'(correct),   32'd0);
    chk("p1_occ0", 32'(occupancy), 32'd0);
    idle_inputs();
    step();
    chk("p1_upd_off",  32'(update_en), 32'd0);
    chk("p1_idx_hold", idx,            32'h100);

    // Fill to DEPTH, pred = idx[0]; pointers wrap since they start at 1
    for (int i = 0; i < 8; i++) begin
      lookup_valid = 1'b1; lookup_idx = 32'(i); pred = i[0];
      step();
    end
    chk("full_ready", 32'(lookup_ready), 32'd0);
    chk("full_occ",   32'(occupancy),    32'd8);
    lookup_idx = 32'd8; pred = 1'b1;
    step();
    chk("drop_occ", 32'(occupancy), 32'd8);

    // At full: push 0x99 and resolve together; push refused
    lookup_idx = 32'h99; pred = 1'b1;
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    step();
    chk("fpp_occ",  32'(occupancy), 32'd7);
    chk("fpp_upd",  32'(update_en), 32'd1);
    chk("fpp_idx",  idx,            32'd0);
    chk("fpp_corr", 32'(correct),   32'd0);
    chk("fpp_br",   32'(br_result), 32'd1);
    idle_inputs();

    // Drain the rest in order; taken=1 so correct = odd index
    for (int i = 1; i < 8; i++) begin
      resolve_valid = 1'b1; resolve_taken = 1'b1;
      step();
      chk("drain_upd",  32'(update_en), 32'd1);
      chk("drain_idx",  idx,            32'(i));
      chk("drain_corr", 32'(correct),   32'(i % 2));
    end
    idle_inputs();
    step();
    chk("drain_occ0", 32'(occupancy), 32'd0);
    chk("drain_upd0", 32'(update_en), 32'd0);
    chk("drain_err0", 32'(resolve_err), 32'd0);

    // Resolve on empty with same-cycle push
    lookup_valid = 1'b1; lookup_idx = 32'h55; pred = 1'b1;
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    step();
    chk("emp_upd", 32'(update_en),   32'd0);
    chk("emp_err", 32'(resolve_err), 32'd1);
    chk("emp_occ", 32'(occupancy),   32'd1);
    idle_inputs();
    step();
    chk("emp_err_hold", 32'(resolve_err), 32'd1);
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    step();
    chk("emp_pop_idx",  idx,            32'h55);
    chk("emp_pop_corr", 32'(correct),   32'd1);
    chk("emp_pop_occ",  32'(occupancy), 32'd0);
    idle_inputs();

    // Hold 3 entries then flush with resolve and push
    for (int i = 1; i <= 3; i++) begin
      lookup_valid = 1'b1; lookup_idx = 32'(i); pred = 1'b0;
      step();
    end
    chk("fl_pre_occ", 32'(occupancy), 32'd3);
    lookup_idx = 32'h77;
    resolve_valid = 1'b1; resolve_taken = 1'b0; flush = 1'b1;
    step();
    chk("fl_upd", 32'(update_en),   32'd0);
    chk("fl_occ", 32'(occupancy),   32'd0);
    chk("fl_err", 32'(resolve_err), 32'd1);
    idle_inputs();
    lookup_valid = 1'b1; lookup_idx = 32'h40; pred = 1'b0;
    step();
    idle_inputs();
    resolve_valid = 1'b1; resolve_taken = 1'b0;
    step();
    chk("fl_post_upd",  32'(update_en), 32'd1);
    chk("fl_post_idx",  idx,            32'h40);
    chk("fl_post_corr", 32'(correct),   32'd1);
    idle_inputs();

    // Reset during a pop suppresses the update and clears the error
    lookup_valid = 1'b1; lookup_idx = 32'hA; pred = 1'b1;
    step();
    idle_inputs();
    resolve_valid = 1'b1; resolve_taken = 1'b1; rst = 1'b1;
    step();
    chk("mrst_upd", 32'(update_en),   32'd0);
    chk("mrst_occ", 32'(occupancy),   32'd0);
    chk("mrst_err", 32'(resolve_err), 32'd0);
    chk("mrst_idx", idx,              32'd0);
    rst = 1'b0;
    idle_inputs();
    step();

`ifdef BUQ_STATS_EN
    chk("st_rst_upd", upd_count,     32'd0);
    chk("st_rst_mis", mispred_count, 32'd0);
    for (int i = 0; i < 5; i++) begin
      lookup_valid = 1'b1; lookup_idx = 32'(i); pred = 1'b1;
      step();
    end
    idle_inputs();
    // taken sequence 1,0,1,0,1 against pred 1 -> two mispredictions
    for (int i = 0; i < 5; i++) begin
      resolve_valid = 1'b1; resolve_taken = ~i[0];
      step();
    end
    idle_inputs();
    step();
    chk("st_upd", upd_count,     32'd5);
    chk("st_mis", mispred_count, 32'd2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("st_flush_upd", upd_count, 32'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("st_clr_upd", upd_count,     32'd0);
    chk("st_clr_mis", mispred_count, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
